// File: rtl/skeleton.sv
// ============================================================================
// Module   : skeleton
// Purpose  : Start/arm/run/done sequencer with an 8-cycle run counter and a registered input parity.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module skeleton (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   output logic d,
   output logic e,
   output logic f
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0] CNT_LAST = 3'd7;

   state_t     state;
   logic [2:0] cnt;

   // e and f are set on the same edge as the state they decode, so they
   // always equal (state == RUN) and (state == DONE) respectively.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 3'd0;
         d     <= 1'b0;
         e     <= 1'b0;
         f     <= 1'b0;
      end else begin
         d <= a ^ b ^ c;
         e <= 1'b0;
         f <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= 3'd0;
               if (a) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (!c) begin
                  state <= IDLE;
               end else if (b) begin
                  state <= RUN;
                  cnt   <= 3'd0;
                  e     <= 1'b1;
               end
            end
            RUN: begin
               // Abort outranks completion.
               if (!c) begin
                  state <= IDLE;
                  cnt   <= 3'd0;
               end else if (cnt == CNT_LAST) begin
                  state <= DONE;
                  cnt   <= 3'd0;
                  f     <= 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
                  e   <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= 3'd0;
            end
            default: begin
               state <= IDLE;
               cnt   <= 3'd0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_skeleton.sv
// ============================================================================
// Module   : tb_skeleton
// Purpose  : Directed self-checking bench for skeleton.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_skeleton;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a = 1'b0;
   logic b = 1'b0;
   logic c = 1'b0;
   logic d;
   logic e;
   logic f;

   int total = 0;
   int bad   = 0;

   skeleton dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .e   (e),
      .f   (f)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample well clear of it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic va, input logic vb, input logic vc);
      a = va;
      b = vb;
      c = vc;
   endtask

   // IDLE -> ARMED -> RUN; returns with the first RUN cycle visible.
   task automatic start_run();
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b1);
   endtask

   // Fixed window from the first RUN cycle; c stays high throughout.
   task automatic measure_run(input string tag);
      int ecnt;
      int fcnt;
      int last_e;
      int f_at;
      int both;
      ecnt = 0; fcnt = 0; last_e = -1; f_at = -1; both = 0;
      for (int i = 0; i < 14; i++) begin
         if (e) begin ecnt++; last_e = i; end
         if (f) begin fcnt++; f_at = i; end
         if (e && f) both++;
         tick();
      end
      chk({tag, "_e_cycles"}, ecnt, 8);
      chk({tag, "_f_cycles"}, fcnt, 1);
      chk({tag, "_f_follows_e"}, f_at, last_e + 1);
      chk({tag, "_e_f_overlap"}, both, 0);
      chk({tag, "_end_e"}, e, 0);
      chk({tag, "_end_f"}, f, 0);
   endtask

   initial begin
      // Reset held with all inputs high.
      drive(1'b1, 1'b1, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_d0", d, 0);
      chk("rst_e0", e, 0);
      chk("rst_f0", f, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_hold_d", d, 0);
         chk("rst_hold_e", e, 0);
         chk("rst_hold_f", f, 0);
      end
      rst = 1'b0;
      tick();
      chk("post_rst_d", d, 1);
      chk("post_rst_e", e, 0);
      tick();
      chk("post_rst_armed_to_run", e, 1);
      drive(1'b0, 1'b0, 1'b0);
      tick();
      chk("post_rst_abort_e", e, 0);
      chk("post_rst_abort_d", d, 0);

      // Nominal run.
      start_run();
      chk("nom_run_entry_e", e, 1);
      chk("nom_run_entry_d", d, 0);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("nom_run_e", e, 1);
         chk("nom_run_d", d, 1);
      end
      tick();
      chk("nom_done_e", e, 0);
      chk("nom_done_f", f, 1);
      // a in DONE must not arm.
      drive(1'b1, 1'b0, 1'b0);
      tick();
      chk("nom_after_done_f", f, 0);
      chk("nom_after_done_e", e, 0);
      drive(1'b0, 1'b1, 1'b1);
      tick();
      tick();
      chk("done_a_not_latched", e, 0);
      drive(1'b0, 1'b0, 1'b0);
      tick();

      // Abort after three RUN cycles.
      start_run();
      chk("abort_run1", e, 1);
      tick();
      chk("abort_run2", e, 1);
      tick();
      chk("abort_run3", e, 1);
      drive(1'b0, 1'b0, 1'b0);
      tick();
      chk("abort_e_fall", e, 0);
      chk("abort_no_f", f, 0);
      drive(1'b0, 1'b1, 1'b1);
      tick();
      chk("abort_idle_no_f", f, 0);
      tick();
      chk("abort_idle_no_run", e, 0);
      drive(1'b0, 1'b0, 1'b0);
      tick();

      // ARMED hold then exit.
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("armed_hold_e", e, 0);
      end
      drive(1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1);
      tick();
      tick();
      chk("armed_exit_no_run", e, 0);

      // ARMED hold must still allow a later start.
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      drive(1'b0, 1'b1, 1'b1);
      tick();
      chk("armed_hold_then_run", e, 1);
      drive(1'b0, 1'b0, 1'b0);
      tick();

      // Parity over all eight combinations.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = i[2:0];
         drive(v[2], v[1], v[0]);
         tick();
         chk($sformatf("parity_%0d", i), d, {31'd0, ^v});
      end
      drive(1'b0, 1'b0, 1'b0);
      tick();
      tick();

      // Async reset at cnt=4.
      start_run();
      for (int i = 0; i < 4; i++) tick();
      chk("async_pre_e", e, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_e_drop", e, 0);
      chk("async_f_low", f, 0);
      tick();
      chk("async_hold_e", e, 0);
      chk("async_hold_f", f, 0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      tick();
      start_run();
      measure_run("rerun");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      bad++;
      $display("FAIL timeout: got running expected finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/skeleton.md
SKELETON -- requirements
Module: skeleton

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high; forces all state and outputs to reset values immediately.
REQ-004 a  input  1  start request.
REQ-005 b  input  1  advance qualifier.
REQ-006 c  input  1  enable/hold; low aborts activity.
REQ-007 d  output  1  registered parity of a, b, c.
REQ-008 e  output  1  registered busy flag, high while FSM in RUN.
REQ-009 f  output  1  registered done pulse, high for exactly one cycle in DONE.

Function
REQ-010 State: 2-bit FSM {IDLE, ARMED, RUN, DONE} plus 3-bit counter cnt; no other storage except the output registers.
REQ-011 IDLE: a=1 -> ARMED; else stay IDLE; cnt held at 0.
REQ-012 ARMED: c=1 and b=1 -> RUN with cnt cleared to 0; c=0 -> IDLE; otherwise stay ARMED; a ignored.
REQ-013 RUN: c=0 -> IDLE, cnt cleared (abort has priority over count completion).
REQ-014 RUN with c=1 and cnt<7: cnt increments by 1, stay RUN; b ignored.
REQ-015 RUN with c=1 and cnt=7: -> DONE, cnt cleared to 0; cnt never wraps inside RUN.
REQ-016 DONE: unconditionally -> IDLE next edge; inputs ignored; a=1 in DONE is not latched.
REQ-017 d <= a ^ b ^ c at every rising edge; one-cycle latency, independent of FSM state.
REQ-018 e and f are decoded from the state register: e=1 iff state=RUN, f=1 iff state=DONE; never both high.
REQ-019 Minimum start-to-done latency: edge sampling a=1 (-> ARMED), edge sampling b=c=1 (-> RUN), 8 RUN edges with c=1 (cnt 0..7), then DONE; e high 8 cycles, f high 1 cycle.
REQ-020 No X propagation: all next-state logic fully specified for every input combination.

Reset
REQ-021 rst=1 asynchronously sets state=IDLE, cnt=0, d=0, e=0, f=0.
REQ-022 While rst=1 all clock edges are ignored; outputs hold reset values.
REQ-023 Reset asserted mid-RUN or in DONE aborts immediately; f is not emitted.
REQ-024 After rst deasserts, first rising edge evaluates normally from IDLE.

Verification
REQ-025 Reset: rst=1 for 2 cycles with a=b=c=1 -> d=e=f=0 throughout; first edge after release gives d=1 and state ARMED.
REQ-026 Nominal run: a=1 one edge, then a=0,b=1,c=1 one edge, then b=0,c=1 held -> e high exactly 8 cycles, f high exactly 1 cycle following e, then e=f=0.
REQ-027 Abort: enter RUN, drop c=0 after 3 RUN cycles -> e falls next edge, f never asserts, state IDLE.
REQ-028 ARMED hold/exit: ARMED with c=1,b=0 for 5 edges -> stays ARMED (e=0); then c=0 -> IDLE; a later b=c=1 without a does not start RUN.
REQ-029 Parity: drive a,b,c through all 8 combinations, one per cycle -> d equals a^b^c of the prior edge (000->0, 111->1, 011->0, 001->1).
REQ-030 Async reset mid-RUN: assert rst between edges at cnt=4 -> e drops before the next edge; after release a full new run completes with 8-cycle e.
